// File: rtl/mem_pkg.sv
// Shared constants, FSM state type and request range helper for the
// data-memory access controller.
package mem_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int LEN_W     = 8;
  localparam int MEM_DEPTH = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // True when a burst starting at addr with len+1 beats runs past the top
  // of memory. The sum is kept one bit wider so it cannot wrap.
  function automatic logic out_of_bounds(input logic [ADDR_W-1:0] addr,
                                         input logic [LEN_W-1:0]  len);
    logic [ADDR_W:0] last;
    last = {1'b0, addr} + (ADDR_W+1)'(len);
    return last > (ADDR_W+1)'(MEM_DEPTH - 1);
  endfunction

endpackage

// File: rtl/mem_rsp_reg.sv
// One-entry response holding register. A captured read byte stays on
// rsp_data with rsp_valid high until the consumer takes it; stall tells the
// controller not to issue another read while the slot is still occupied.
module mem_rsp_reg
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_en,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              rsp_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              stall
);

  assign stall = rsp_valid && !rsp_ready;

  // Capture wins over retire, so an accept and a new capture can share a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (cap_en) begin
      rsp_valid <= 1'b1;
      rsp_data  <= cap_data;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for the 256-byte data memory. Takes single or
// burst load/store requests, issues one memory beat per cycle and returns
// read bytes through a back-pressured response register.
// Optional macro MEM_ACCESS_BOUNDS_EN: reject requests that would run past
// address 255 with a one-cycle err pulse instead of wrapping.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// ACCESS | issuing beats, one per unstalled cycle
// DRAIN  | read burst issued, waiting for the last response to be taken
module mem_access_ctrl
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout
);

  state_t            state, state_nx;
  logic              write_q;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] wdata_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_cnt;
  logic              done_q;
  logic              accept;
  logic              bad_req;
  logic              start;
  logic              beat;
  logic              last_beat;
  logic              stall;
  logic              cap_en;
  logic              rsp_taken;

  // done_q also holds off req_ready so a new request lands after the pulse.
  assign req_ready = (state == IDLE) && !reset && !done_q;
  assign accept    = req_valid && req_ready;

`ifdef MEM_ACCESS_BOUNDS_EN
  logic err_q;

  assign bad_req = out_of_bounds(req_addr, req_len);
  assign err     = err_q;

  // One-cycle pulse for each rejected request.
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= accept && bad_req;
  end
`else
  assign bad_req = 1'b0;
  assign err     = 1'b0;
`endif

  assign start     = accept && !bad_req;
  assign beat      = (state == ACCESS) && !stall;
  assign last_beat = beat && (beat_cnt == len_q);
  assign cap_en    = beat && !write_q;
  assign rsp_taken = rsp_valid && rsp_ready;

  assign busy        = (state != IDLE);
  assign done        = done_q;
  assign mem_write   = beat && write_q;
  assign mem_address = (state == ACCESS) ? cur_addr : '0;
  assign mem_datain  = (state == ACCESS) ? wdata_q  : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)     state_nx = ACCESS;
      ACCESS:  if (last_beat) state_nx = write_q ? IDLE : DRAIN;
      DRAIN:   if (rsp_taken) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Request latch, beat address/counter and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q  <= 1'b0;
      cur_addr <= '0;
      wdata_q  <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (last_beat && write_q) || ((state == DRAIN) && rsp_taken);
      if (start) begin
        write_q  <= req_write;
        cur_addr <= req_addr;
        wdata_q  <= req_wdata;
        len_q    <= req_len;
        beat_cnt <= '0;
      end else if (beat) begin
        cur_addr <= cur_addr + 1'b1;
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  mem_rsp_reg u_rsp (
    .clk       (clk),
    .reset     (reset),
    .cap_en    (cap_en),
    .cap_data  (mem_dataout),
    .rsp_ready (rsp_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .stall     (stall)
  );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: negedge-sampling memory model, scoreboarded
// write and response streams, directed scenarios and a randomized phase.
module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata, req_len;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       done, busy, err;
  logic       mem_write;
  logic [7:0] mem_address, mem_datain, mem_dataout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int hs_cyc  = 0;
  int wr_cycles  = 0;
  int n_err_seen = 0;
  int n_err_exp  = 0;
  int hold_token = 0;
  bit rand_ready = 1'b0;

  logic [7:0]  mmem [256];
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_rsp [$];

  mem_access_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .done(done), .busy(busy), .err(err),
    .mem_write(mem_write), .mem_address(mem_address),
    .mem_datain(mem_datain), .mem_dataout(mem_dataout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Data memory: commits writes and registers the read address on negedge.
  initial begin
    logic [7:0] ram [256];
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    mem_dataout = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_write) ram[mem_address] = mem_datain;
      mem_dataout = ram[mem_address];
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Response consumer: always ready, random, or a 4-cycle hold on request.
  initial begin
    int local_hold = 0;
    int seen = 0;
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_token != seen) begin
        seen = hold_token;
        local_hold = 4;
      end
      if (local_hold > 0) begin
        rsp_ready = 1'b0;
        local_hold--;
      end else begin
        rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Scoreboard: memory writes, responses in order, held responses, err count.
  initial begin
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (mem_write) begin
        wr_cycles++;
        check("write outside access", busy, 1);
        check("write pending", exp_wr.size() > 0, 1);
        if (exp_wr.size() > 0) begin
          e = exp_wr.pop_front();
          check("wr addr", mem_address, e[15:8]);
          check("wr data", mem_datain, e[7:0]);
        end
      end
      if (prev_stall) begin
        check("rsp held valid", rsp_valid, 1);
        check("rsp held data", rsp_data, prev_data);
      end
      if (rsp_valid && !rsp_ready) check("stall mem_write", mem_write, 0);
      if (rsp_valid && rsp_ready) begin
        check("rsp pending", exp_rsp.size() > 0, 1);
        if (exp_rsp.size() > 0) check("rsp data", rsp_data, exp_rsp.pop_front());
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
      if (err) n_err_seen++;
    end
  end

  function automatic bit rejected(input logic [7:0] a, input logic [7:0] l);
    return BOUNDS && (int'(a) + int'(l) > 255);
  endfunction

  // Reference: a burst touches addresses a..a+l modulo 256, in order.
  task automatic model_push(input bit w, input logic [7:0] a, d, l);
    logic [7:0] ad;
    if (rejected(a, l)) return;
    for (int i = 0; i <= int'(l); i++) begin
      ad = 8'((int'(a) + i) % 256);
      if (w) begin
        exp_wr.push_back({ad, d});
        mmem[ad] = d;
      end else begin
        exp_rsp.push_back(mmem[ad]);
      end
    end
  endtask

  task automatic send_req(input bit w, input logic [7:0] a, d, l, input bit model);
    int t = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_len = l;
    forever begin
      @(negedge clk);
      if (req_ready || t > 100) break;
      t++;
    end
    check("req_ready seen", req_ready, 1);
    hs_cyc = cyc + 1;
    if (model) model_push(w, a, d, l);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input bit w, input logic [7:0] l, input bit timed);
    int t = 0;
    bit seen = 1'b0;
    while (t < 4000 && !seen) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else t++;
    end
    check("done seen", seen, 1);
    if (timed && seen) check("done cycle", cyc, hs_cyc + int'(l) + 1 + (w ? 0 : 1));
    check("busy at done", busy, 0);
    @(negedge clk);
    check("done width", done, 0);
    check("ready after done", req_ready, 1);
    check("writes left", exp_wr.size(), 0);
    check("rsps left", exp_rsp.size(), 0);
  endtask

  task automatic do_req(input bit w, input logic [7:0] a, d, l, input bit timed);
    bit rej;
    rej = rejected(a, l);
    send_req(w, a, d, l, 1'b1);
    if (rej) begin
      n_err_exp++;
      @(negedge clk);
      check("err pulse", err, 1);
      check("err ready", req_ready, 1);
      check("err busy", busy, 0);
      @(negedge clk);
      check("err width", err, 0);
      check("err no done", done, 0);
    end else begin
      wait_done(w, l, timed);
    end
  endtask

  initial begin
    int w0;
    logic [7:0] ra, rd, rl;
    bit rw;
    for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 8'h00; req_wdata = 8'h00; req_len = 8'h00;

    repeat (3) @(negedge clk);
    check("ready in reset", req_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst mem_write", mem_write, 0);
    check("rst mem_address", mem_address, 0);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst ready", req_ready, 1);

    // Single store then single load at 0x10.
    w0 = wr_cycles;
    do_req(1'b1, 8'h10, 8'hA5, 8'd0, 1'b1);
    check("store wr cycles", wr_cycles - w0, 1);
    send_req(1'b0, 8'h10, 8'h00, 8'd0, 1'b1);
    @(negedge clk);
    check("load rsp early", rsp_valid, 0);
    @(negedge clk);
    check("load latency", rsp_valid, 1);
    check("load data", rsp_data, 8'hA5);
    wait_done(1'b0, 8'd0, 1'b0);

    // Fill then overlapping read burst.
    do_req(1'b1, 8'h20, 8'h3C, 8'd3, 1'b1);
    do_req(1'b0, 8'h1F, 8'h00, 8'd5, 1'b1);

    // Read burst with a 4-cycle consumer hold after the first response.
    w0 = wr_cycles;
    send_req(1'b0, 8'h20, 8'h00, 8'd3, 1'b1);
    @(negedge clk);
    check("stall rsp early", rsp_valid, 0);
    @(negedge clk);
    check("stall first rsp", rsp_valid, 1);
    hold_token++;
    wait_done(1'b0, 8'd3, 1'b0);
    check("stall no writes", wr_cycles - w0, 0);

    // Wrap across the top of memory, and the in-bounds edge cases.
    w0 = wr_cycles;
    do_req(1'b1, 8'hFE, 8'h5A, 8'd2, 1'b1);
    check("wrap wr cycles", wr_cycles - w0, BOUNDS ? 0 : 3);
    do_req(1'b0, 8'hFE, 8'h00, 8'd2, 1'b1);
    do_req(1'b1, 8'hFF, 8'h11, 8'd0, 1'b1);
    do_req(1'b1, 8'hFF, 8'h22, 8'd1, 1'b1);
    do_req(1'b0, 8'h00, 8'h00, 8'd255, 1'b1);

    // Reset during the second beat of an 8-beat fill at 0x40.
    mmem[8'h40] = 8'h77;
    mmem[8'h41] = 8'h77;
    exp_wr.push_back({8'h40, 8'h77});
    exp_wr.push_back({8'h41, 8'h77});
    send_req(1'b1, 8'h40, 8'h77, 8'd7, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort mem_write", mem_write, 0);
    check("abort mem_address", mem_address, 0);
    check("abort mem_datain", mem_datain, 0);
    check("abort rsp_valid", rsp_valid, 0);
    check("abort rsp_data", rsp_data, 0);
    check("abort done", done, 0);
    check("abort busy", busy, 0);
    check("abort err", err, 0);
    check("abort ready", req_ready, 1);
    check("abort writes", exp_wr.size(), 0);
    repeat (10) @(negedge clk);
    check("abort no late writes", exp_wr.size(), 0);
    do_req(1'b0, 8'h3F, 8'h00, 8'd3, 1'b1);

    // Randomized requests with a randomly stalling consumer.
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rw = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rd = 8'($urandom);
      rl = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
      do_req(rw, ra, rd, rl, 1'b0);
    end
    rand_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("err count", n_err_seen, n_err_exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
